andn_seq: RTL

Multi-cycle AND-reduction sequencer. Accepts a wide operand over a valid/ready handshake and walks it one CHUNK-bit slice per cycle through a single narrow `andn` datapath instance. Returns the reduced result plus the index of the first failing slice. This trades latency for area, and it is the controller used wherever a wide all-ones check is too large to do in one cycle.

---
 rtl/andn_seq_pkg.sv | 16 +
 rtl/andn.sv | 13 +
 rtl/andn_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/andn_seq_pkg.sv
// andn_seq_pkg: shared types and helpers for the andn_seq sequencer.
//   andn_seq_state_t : controller states (IDLE, RUN, DONE)
//   ceil_div(a, b)   : integer ceiling division, used to size the slice count
package andn_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } andn_seq_state_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/andn.sv
// andn: combinational AND-reduction of a width-bit vector.
//   a : operand (width bits)
//   y : 1 when every bit of a is 1
module andn #(
    parameter int unsigned width = 4
) (
    input  logic [width-1:0] a,
    output logic             y
);

    assign y = &a;

endmodule

// File: rtl/andn_seq.sv
// andn_seq: multi-cycle AND-reduction sequencer. A WIDTH-bit operand is
// accepted over a valid/ready handshake and reduced one CHUNK-bit slice per
// cycle through a single andn instance. The result and the index of the
// lowest slice containing a 0 are held until the consumer takes them.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid        : operand offered (ignored outside IDLE)
//   in_ready        : block can accept an operand (state == IDLE)
//   in_data         : WIDTH-bit operand
//   out_valid       : result available (state == DONE)
//   out_ready       : consumer takes the result
//   out_y           : AND of all operand bits
//   out_fail_chunk  : lowest failing slice index when out_y = 0, else 0
//
// Configuration macro: ANDN_SEQ_EARLY_EXIT_EN
//   When defined, RUN ends on the first failing slice instead of always
//   walking all NCHUNK slices. Result values are identical either way.
module andn_seq
    import andn_seq_pkg::*;
#(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned CHUNK  = 4,
    localparam int unsigned NCHUNK = ceil_div(WIDTH, CHUNK),
    localparam int unsigned CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_y,
    output logic [CIDX_W-1:0] out_fail_chunk
);

    andn_seq_state_t state, state_next;

    logic [WIDTH-1:0]        operand;
    logic [NCHUNK*CHUNK-1:0] padded;
    logic [CHUNK-1:0]        slice;
    logic                    slice_y;
    logic                    acc;
    logic [CIDX_W-1:0]       idx;
    logic [CIDX_W-1:0]       fail;
    logic                    last;
    logic                    stop;

    // Bits beyond WIDTH in the last slice read as 1 so they never fail.
    always_comb begin
        padded              = '1;
        padded[WIDTH-1:0]   = operand;
    end

    assign slice = padded[int'(idx) * int'(CHUNK) +: CHUNK];

    andn #(.width(CHUNK)) u_andn (
        .a (slice),
        .y (slice_y)
    );

    assign last = (idx == CIDX_W'(NCHUNK - 1));

`ifdef ANDN_SEQ_EARLY_EXIT_EN
    assign stop = last || !slice_y;
`else
    assign stop = last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (stop)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand <= '0;
            acc     <= 1'b0;
            idx     <= '0;
            fail    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        operand <= in_data;
                        acc     <= 1'b1;
                        idx     <= '0;
                        fail    <= '0;
                    end
                end
                RUN: begin
                    acc <= acc & slice_y;
                    // Only the first failing slice is recorded.
                    if (acc && !slice_y) begin
                        fail <= idx;
                    end
                    if (!last) begin
                        idx <= idx + CIDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state and registers only; outside DONE they sit at
    // their reset values, so a reset mid-transaction hides any partial result.
    assign in_ready       = (state == IDLE);
    assign out_valid      = (state == DONE);
    assign out_y          = out_valid & acc;
    assign out_fail_chunk = (out_valid && !acc) ? fail : '0;

endmodule
